// File: rtl/sobel_pkg.sv
// Shared types and geometry constants for the Sobel frame sequencer.
// A tile is a 4x4 input window yielding a 2x2 block of magnitude pixels.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    LOAD     = 3'd2,
    WAIT_PIX = 3'd3,
    DONE     = 3'd4
  } seq_state_t;

  localparam int TILE_DIM      = 4;
  localparam int TILE_STRIDE   = 2;
  localparam int PIX_PER_TILE  = 4;
  // A 3x3 kernel loses one pixel on each side, so the output image is 2 narrower.
  localparam int KERNEL_BORDER = 2;

endpackage

// File: rtl/sobel_tile_addr_gen.sv
// Tile origin counters plus output-address arithmetic for the pixel currently
// being collected (k selects the (dx,dy) position inside the 2x2 output block).
module sobel_tile_addr_gen
  import sobel_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [1:0]        k,
  output logic [DIM_W-1:0]  tile_x,
  output logic [DIM_W-1:0]  tile_y,
  output logic              last_tile,
  output logic [ADDR_W-1:0] pix_addr
);

  logic [DIM_W-1:0]  last_x_s;
  logic [DIM_W-1:0]  last_y_s;
  logic [ADDR_W-1:0] row_s;
  logic [ADDR_W-1:0] col_s;
  logic [ADDR_W-1:0] stride_s;

  assign last_x_s  = cfg_w - DIM_W'(TILE_DIM);
  assign last_y_s  = cfg_h - DIM_W'(TILE_DIM);
  assign last_tile = (tile_x == last_x_s) && (tile_y == last_y_s);

  // k is dy-major: bit 1 selects the row offset, bit 0 the column offset.
  assign row_s    = ADDR_W'(tile_y) + ADDR_W'(k[1]);
  assign col_s    = ADDR_W'(tile_x) + ADDR_W'(k[0]);
  assign stride_s = ADDR_W'(cfg_w) - ADDR_W'(KERNEL_BORDER);
  assign pix_addr = (row_s * stride_s) + col_s;

  // Raster walk of tile origins: step right, wrap to next tile row at the right edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tile_x <= '0;
      tile_y <= '0;
    end else if (clear) begin
      tile_x <= '0;
      tile_y <= '0;
    end else if (advance) begin
      if (tile_x == last_x_s) begin
        tile_x <= '0;
        tile_y <= tile_y + DIM_W'(TILE_STRIDE);
      end else begin
        tile_x <= tile_x + DIM_W'(TILE_STRIDE);
        tile_y <= tile_y;
      end
    end else begin
      tile_x <= tile_x;
      tile_y <= tile_y;
    end
  end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame-level controller: fetches each tile, pulses the buffer load, collects
// four magnitude pixels per tile and tags them with output-image addresses.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int PIX_W   = 4,
  parameter int DIM_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  output logic              tile_req,
  output logic [DIM_W-1:0]  tile_x,
  output logic [DIM_W-1:0]  tile_y,
  input  logic              tile_ack,
  output logic              load_enable,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_in,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              busy,
  output logic              frame_done,
  output logic              err_cfg,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_t        state_r;
  logic [DIM_W-1:0]  cfg_w_r;
  logic [DIM_W-1:0]  cfg_h_r;
  logic [1:0]        k_r;
  logic [WD_W-1:0]   wd_r;
  logic              tile_req_r;
  logic              load_enable_r;
  logic              out_valid_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic [PIX_W-1:0]  out_pixel_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              err_cfg_r;
  logic              err_timeout_r;

  logic              cfg_ok_s;
  logic              accept_s;
  logic              pix_take_s;
  logic              tile_end_s;
  logic              advance_s;
  logic              last_tile_s;
  logic [ADDR_W-1:0] pix_addr_s;

  assign cfg_ok_s   = ~cfg_width[0] & ~cfg_height[0] &
                      (cfg_width  >= DIM_W'(TILE_DIM)) &
                      (cfg_height >= DIM_W'(TILE_DIM));
  assign accept_s   = (state_r == IDLE) & start & ~abort & cfg_ok_s;
  assign pix_take_s = (state_r == WAIT_PIX) & pix_valid;
  assign tile_end_s = pix_take_s & (k_r == 2'(PIX_PER_TILE - 1));
  assign advance_s  = tile_end_s & ~last_tile_s & ~abort;

  sobel_tile_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (accept_s),
    .advance   (advance_s),
    .cfg_w     (cfg_w_r),
    .cfg_h     (cfg_h_r),
    .k         (k_r),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .last_tile (last_tile_s),
    .pix_addr  (pix_addr_s)
  );

  // Sequencer FSM with watchdog and registered outputs; abort overrides every state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      cfg_w_r       <= '0;
      cfg_h_r       <= '0;
      k_r           <= 2'd0;
      wd_r          <= '0;
      tile_req_r    <= 1'b0;
      load_enable_r <= 1'b0;
      out_valid_r   <= 1'b0;
      out_addr_r    <= '0;
      out_pixel_r   <= '0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      err_cfg_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      load_enable_r <= 1'b0;
      frame_done_r  <= 1'b0;
      err_cfg_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      // A pixel accepted this cycle is emitted even if abort arrives alongside it.
      out_valid_r   <= pix_take_s;
      if (pix_take_s) begin
        out_addr_r  <= pix_addr_s;
        out_pixel_r <= pix_in;
      end else begin
        out_addr_r  <= out_addr_r;
        out_pixel_r <= out_pixel_r;
      end

      if (abort) begin
        state_r    <= IDLE;
        tile_req_r <= 1'b0;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start && cfg_ok_s) begin
              cfg_w_r    <= cfg_width;
              cfg_h_r    <= cfg_height;
              state_r    <= REQ;
              tile_req_r <= 1'b1;
              busy_r     <= 1'b1;
            end else if (start) begin
              err_cfg_r  <= 1'b1;
            end else begin
              state_r    <= IDLE;
            end
          end
          REQ: begin
            if (tile_ack) begin
              state_r       <= LOAD;
              tile_req_r    <= 1'b0;
              load_enable_r <= 1'b1;
            end else begin
              state_r       <= REQ;
            end
          end
          LOAD: begin
            state_r <= WAIT_PIX;
            k_r     <= 2'd0;
            wd_r    <= '0;
          end
          WAIT_PIX: begin
            if (pix_valid) begin
              wd_r <= '0;
              k_r  <= k_r + 2'd1;
              if (tile_end_s && last_tile_s) begin
                state_r      <= DONE;
                frame_done_r <= 1'b1;
              end else if (tile_end_s) begin
                state_r    <= REQ;
                tile_req_r <= 1'b1;
              end else begin
                state_r    <= WAIT_PIX;
              end
            end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
              err_timeout_r <= 1'b1;
              state_r       <= IDLE;
              busy_r        <= 1'b0;
            end else begin
              wd_r <= wd_r + WD_W'(1);
            end
          end
          DONE: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r    <= IDLE;
            tile_req_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tile_req    = tile_req_r;
  assign load_enable = load_enable_r;
  assign out_valid   = out_valid_r;
  assign out_addr    = out_addr_r;
  assign out_pixel   = out_pixel_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign err_cfg     = err_cfg_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Randomised bench for sobel_frame_sequencer: drives whole frames and compares
// the emitted tiles, addresses and pixels against a raster-order reference.
module tb_sobel_frame_sequencer;

  localparam int PIX_W   = 4;
  localparam int DIM_W   = 8;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic              abort;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic              tile_req;
  logic [DIM_W-1:0]  tile_x;
  logic [DIM_W-1:0]  tile_y;
  logic              tile_ack;
  logic              load_enable;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_in;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [PIX_W-1:0]  out_pixel;
  logic              busy;
  logic              frame_done;
  logic              err_cfg;
  logic              err_timeout;

  sobel_frame_sequencer #(
    .PIX_W(PIX_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .tile_req(tile_req), .tile_x(tile_x), .tile_y(tile_y), .tile_ack(tile_ack),
    .load_enable(load_enable), .pix_valid(pix_valid), .pix_in(pix_in),
    .out_valid(out_valid), .out_addr(out_addr), .out_pixel(out_pixel),
    .busy(busy), .frame_done(frame_done), .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  wire [42:0] all_out = {tile_req, tile_x, tile_y, load_enable, out_valid, out_addr,
                         out_pixel, busy, frame_done, err_cfg, err_timeout};

  int n_tests = 0;
  int n_fail  = 0;

  int obs_addr[$], obs_pix[$], req_x[$], req_y[$];
  int exp_addr[$], exp_pix[$], exp_tx[$], exp_ty[$];
  int done_cnt, done_with_valid, errcfg_cnt, errto_cnt, load_cnt, busy_cnt;
  bit prev_req;

  // Observation recorder, sampling just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      obs_addr.push_back(int'(out_addr));
      obs_pix.push_back(int'(out_pixel));
    end
    if (frame_done) begin
      done_cnt++;
      if (out_valid) done_with_valid++;
    end
    if (err_cfg) errcfg_cnt++;
    if (err_timeout) errto_cnt++;
    if (busy) busy_cnt++;
    if (load_enable) load_cnt++;
    if (tile_req && !prev_req) begin
      req_x.push_back(int'(tile_x));
      req_y.push_back(int'(tile_y));
    end
    prev_req = tile_req;
  end

  task automatic clear_obs();
    obs_addr.delete(); obs_pix.delete(); req_x.delete(); req_y.delete(); exp_pix.delete();
    done_cnt = 0; done_with_valid = 0; errcfg_cnt = 0; errto_cnt = 0;
    load_cnt = 0; busy_cnt = 0;
  endtask

  // Reference: tiles in raster order at stride 2, each giving a 2x2 block of the (W-2)-wide output.
  task automatic build_model(input int w, input int h);
    exp_addr.delete(); exp_tx.delete(); exp_ty.delete();
    for (int ty = 0; ty <= h - 4; ty += 2)
      for (int tx = 0; tx <= w - 4; tx += 2) begin
        exp_tx.push_back(tx);
        exp_ty.push_back(ty);
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            exp_addr.push_back(((ty + dy) * (w - 2) + tx + dx) % 65536);
      end
  endtask

  function automatic int frame_errs();
    int e = 0;
    if (obs_addr.size() != exp_addr.size()) e++;
    if (obs_pix.size() != exp_pix.size()) e++;
    if (req_x.size() != exp_tx.size()) e++;
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size() && i < exp_pix.size(); i++)
      if (obs_addr[i] != exp_addr[i] || obs_pix[i] != exp_pix[i]) e++;
    for (int i = 0; i < req_x.size() && i < exp_tx.size(); i++)
      if (req_x[i] != exp_tx[i] || req_y[i] != exp_ty[i]) e++;
    return e;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tile_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input int w, input int h);
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pixel();
    pix_valid = 1'b1;
    pix_in    = PIX_W'($urandom_range(0, 15));
    exp_pix.push_back(int'(pix_in));
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic ack_tile(input int ack_dly);
    repeat (ack_dly) @(negedge clk);
    tile_ack = 1'b1;
    @(negedge clk);
    tile_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_tile(input int ack_dly, input int max_gap);
    bit ok;
    wait_req(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tile_req_wait: tile_req=%0b after 40 cycles, required 1", tile_req);
      return;
    end
    ack_tile(ack_dly);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_pixel();
    end
  endtask

  task automatic drive_frame(input int w, input int h, input bit ack_rand, input int max_gap);
    bit ok;
    int tiles = ((w - 2) / 2) * ((h - 2) / 2);
    start_frame(w, h);
    for (int t = 0; t < tiles; t++)
      drive_tile(ack_rand ? int'($urandom_range(0, 3)) : 2, max_gap);
    wait_idle(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_end_wait: busy=%0b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; tile_ack = 1'b0; pix_valid = 1'b0;
    pix_in = '0; cfg_width = '0; cfg_height = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (all_out !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_frame();
    clear_obs();
    build_model(6, 6);
    drive_frame(6, 6, 1'b0, 0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL spec_frame: %0d mismatches (%0d outputs, required %0d), required 0",
               frame_errs(), obs_addr.size(), exp_addr.size());
    end
    n_tests++;
    if (done_cnt !== 1 || done_with_valid !== 1) begin
      n_fail++;
      $display("FAIL spec_frame_done: got %0d pulses (%0d with out_valid), required 1 and 1",
               done_cnt, done_with_valid);
    end
    n_tests++;
    if (load_cnt !== 4) begin
      n_fail++;
      $display("FAIL spec_load_enable: got %0d pulses, required 4", load_cnt);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int w = 4 + 2 * int'($urandom_range(0, 4));
      int h = 4 + 2 * int'($urandom_range(0, 4));
      clear_obs();
      build_model(w, h);
      drive_frame(w, h, 1'b1, 3);
      repeat (2) @(negedge clk);
      n_tests++;
      if (frame_errs() !== 0) begin
        n_fail++;
        $display("FAIL random_frame_%0dx%0d: %0d mismatches, required 0", w, h, frame_errs());
      end
      n_tests++;
      if (done_cnt !== 1 || done_with_valid !== 1) begin
        n_fail++;
        $display("FAIL random_frame_done_%0dx%0d: got %0d pulses, required 1", w, h, done_cnt);
      end
    end
  endtask

  task automatic test_bad_cfg();
    int ws[4] = '{5, 6, 4, 3};
    int hs[4] = '{6, 2, 7, 4};
    for (int i = 0; i < 4; i++) begin
      clear_obs();
      start_frame(ws[i], hs[i]);
      repeat (4) @(negedge clk);
      n_tests++;
      if (errcfg_cnt !== 1) begin
        n_fail++;
        $display("FAIL bad_cfg_%0dx%0d: err_cfg pulses %0d, required 1", ws[i], hs[i], errcfg_cnt);
      end
      n_tests++;
      if (busy_cnt !== 0 || req_x.size() !== 0) begin
        n_fail++;
        $display("FAIL bad_cfg_idle_%0dx%0d: busy cycles %0d, tile_reqs %0d, required 0 and 0",
                 ws[i], hs[i], busy_cnt, req_x.size());
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    clear_obs();
    start_frame(4, 4);
    wait_req(ok);
    ack_tile(1);
    send_pixel();
    send_pixel();
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        n = i;
        break;
      end
    end
    n_tests++;
    if (n !== TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_cycle: err_timeout after %0d stall cycles, required %0d", n, TIMEOUT);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%0b, required 0", busy);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0 || errto_cnt !== 1 || obs_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL timeout_side: frame_done %0d, err_timeout %0d, outputs %0d, required 0,1,2",
               done_cnt, errto_cnt, obs_addr.size());
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_obs();
    start_frame(6, 6);
    drive_tile(2, 1);
    wait_req(ok);
    n_tests++;
    if (!ok || tile_x !== 8'd2 || tile_y !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_tile2_req: req=%0b at (%0d,%0d), required 1 at (2,0)", ok, tile_x, tile_y);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (tile_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: tile_req=%0b busy=%0b, required 0 0", tile_req, busy);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: frame_done pulses %0d, required 0", done_cnt);
    end
    clear_obs();
    build_model(6, 6);
    drive_frame(6, 6, 1'b1, 2);
    repeat (2) @(negedge clk);
    n_tests++;
    if (frame_errs() !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL abort_restart: %0d mismatches, %0d frame_done, required 0 and 1",
               frame_errs(), done_cnt);
    end
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    clear_obs();
    pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL idle_pix_ignored: got %0d out_valid, required 0", obs_addr.size());
    end
    clear_obs();
    build_model(4, 4);
    start_frame(4, 4);
    wait_req(ok);
    pix_valid = 1'b1;
    start = 1'b1;
    cfg_width = 8'd8;
    cfg_height = 8'd8;
    @(negedge clk);
    pix_valid = 1'b0;
    start = 1'b0;
    tile_ack = 1'b1;
    @(negedge clk);
    tile_ack = 1'b0;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    for (int k = 0; k < 4; k++) send_pixel();
    wait_idle(ok);
    repeat (2) @(negedge clk);
    n_tests++;
    if (frame_errs() !== 0) begin
      n_fail++;
      $display("FAIL busy_ignores_inputs: %0d mismatches (%0d outputs), required 0 (4 outputs)",
               frame_errs(), obs_addr.size());
    end
    n_tests++;
    if (done_cnt !== 1 || done_with_valid !== 1) begin
      n_fail++;
      $display("FAIL single_tile_done: got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_obs();
    start_frame(6, 6);
    wait_req(ok);
    ack_tile(0);
    send_pixel();
    send_pixel();
    n_rst = 1'b0;
    #1;
    n_tests++;
    if (all_out !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: outputs %h, required 0", all_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    clear_obs();
    build_model(6, 6);
    drive_frame(6, 6, 1'b1, 1);
    repeat (2) @(negedge clk);
    n_tests++;
    if (frame_errs() !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL reset_restart: %0d mismatches, %0d frame_done, required 0 and 1",
               frame_errs(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_random_frames();
    test_bad_cfg();
    test_timeout();
    test_abort();
    test_ignored_inputs();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
